cmplx_square_ctrl: RTL and testbench

//  Scheduler/controller for the pipelined complex-square datapath (z -> z^2) in the CmplxSquare system.

---
 rtl/cmplx_sq_pkg.sv | 40 ++++
 rtl/cmplx_square_ctrl_fifo.sv | 54 +++++
 rtl/cmplx_square_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cmplx_square_ctrl.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmplx_sq_pkg.sv
// cmplx_sq_pkg: register map, FSM states and result reduction for cmplx_square_ctrl.
// CSQ_SAT_EN selects saturating (defined) or wrapping (undefined) 33->32 bit reduction.
package cmplx_sq_pkg;

  localparam logic [2:0] ADDR_OPERAND = 3'd0;
  localparam logic [2:0] ADDR_RES_RE  = 3'd1;
  localparam logic [2:0] ADDR_RES_IM  = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_CTRL    = 3'd4;

  localparam int ST_OVF_BIT   = 0;
  localparam int ST_UDF_BIT   = 1;
  localparam int ST_CLR_BIT   = 0;
  localparam int ST_FLUSH_BIT = 1;
  localparam int CTRL_RUN_BIT = 0;
  localparam int CTRL_IE_BIT  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  function automatic logic [31:0] csq_reduce(input logic [32:0] x);
    logic [31:0] r;
`ifdef CSQ_SAT_EN
    if (x[32] == x[31])
      r = x[31:0];
    else if (x[32])
      r = 32'h8000_0000;
    else
      r = 32'h7FFF_FFFF;
`else
    r = x[31:0];
`endif
    return r;
  endfunction

endpackage

// File: rtl/cmplx_square_ctrl_fifo.sv
// csq_fifo: synchronous FIFO with occupancy count and synchronous clear.
// Callers gate push on !full and pop on !empty.
module csq_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PONE = AW'(1);
  localparam logic [AW:0]   CONE = (AW+1)'(1);
  localparam logic [AW:0]   CFULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_full  = (r_cnt == CFULL);
  assign o_empty = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PONE;
      if (i_pop)  r_rp <= r_rp + PONE;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CONE;
        2'b01:   r_cnt <= r_cnt - CONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr && !i_rst)
      r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/cmplx_square_ctrl.sv
// cmplx_square_ctrl: Avalon-MM front end and credit scheduler for the z^2 datapath.
// Define CSQ_SAT_EN to saturate results to 32 bits instead of wrapping.
import cmplx_sq_pkg::*;

module cmplx_square_ctrl #(
  parameter int DW        = 16,
  parameter int OP_DEPTH  = 8,
  parameter int RES_DEPTH = 8
) (
  input  logic          clk_clk,
  input  logic          reset_reset,
  input  logic [2:0]    avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata,
  output logic          irq,
  output logic          dp_in_valid,
  output logic [DW-1:0] dp_in_re,
  output logic [DW-1:0] dp_in_im,
  input  logic          dp_out_valid,
  input  logic [2*DW:0] dp_out_re,
  input  logic [2*DW:0] dp_out_im
);
  localparam int OCW = $clog2(OP_DEPTH) + 1;
  localparam int RCW = $clog2(RES_DEPTH) + 1;
  localparam logic [RCW-1:0] OONE = RCW'(1);
  localparam logic [RCW:0]   CRED = (RCW+1)'(RES_DEPTH);

  state_t          r_state;
  logic            r_run;
  logic            r_ie;
  logic            r_ovf;
  logic            r_udf;
  logic [RCW-1:0]  r_outst;
  logic            r_dp_valid;
  logic [DW-1:0]   r_dp_re;
  logic [DW-1:0]   r_dp_im;
  logic [31:0]     r_rdata;

  logic            w_sel_op, w_sel_re, w_sel_im;
  logic            w_sel_st, w_sel_ctl;
  logic            w_in_flush, w_flush_req, w_clr_flags;
  logic            w_wr_ctl, w_fifo_clr;
  logic            w_op_push, w_op_ovf, w_issue;
  logic            w_op_full, w_op_empty;
  logic [OCW-1:0]  w_op_cnt;
  logic [2*DW-1:0] w_op_head;
  logic            w_res_push, w_res_pop, w_udf;
  logic            w_res_full, w_res_empty;
  logic [RCW-1:0]  w_res_cnt;
  logic [63:0]     w_res_head;
  logic [63:0]     w_res_wdata;
  logic [RCW:0]    w_used;
  logic [31:0]     w_status;
  logic [31:0]     w_rdata;

  assign w_sel_op  = (avs_address == ADDR_OPERAND);
  assign w_sel_re  = (avs_address == ADDR_RES_RE);
  assign w_sel_im  = (avs_address == ADDR_RES_IM);
  assign w_sel_st  = (avs_address == ADDR_STATUS);
  assign w_sel_ctl = (avs_address == ADDR_CTRL);

  assign w_in_flush  = (r_state == S_FLUSH);
  assign w_flush_req = avs_write & w_sel_st & avs_writedata[ST_FLUSH_BIT];
  assign w_clr_flags = avs_write & w_sel_st & avs_writedata[ST_CLR_BIT];
  assign w_wr_ctl    = avs_write & w_sel_ctl;
  assign w_fifo_clr  = w_flush_req | w_in_flush;

  // Full is judged at cycle start, so a same-cycle issue does not make room.
  assign w_op_push = avs_write & w_sel_op & ~w_op_full & ~w_in_flush;
  assign w_op_ovf  = avs_write & w_sel_op & w_op_full & ~w_in_flush;

  assign w_used  = {1'b0, r_outst} + {1'b0, w_res_cnt};
  assign w_issue = (r_state == S_RUN) & ~w_op_empty
                 & (w_used < CRED) & ~w_flush_req;

  assign w_res_push  = dp_out_valid & ~w_fifo_clr & ~w_res_full;
  assign w_res_pop   = avs_read & w_sel_im & ~w_res_empty;
  assign w_udf       = avs_read & (w_sel_re | w_sel_im) & w_res_empty;
  assign w_res_wdata = {csq_reduce(dp_out_re), csq_reduce(dp_out_im)};

  csq_fifo #(.W(2*DW), .DEPTH(OP_DEPTH)) u_op_fifo (
    .i_clk   (clk_clk),
    .i_rst   (reset_reset),
    .i_clr   (w_fifo_clr),
    .i_push  (w_op_push),
    .i_pop   (w_issue),
    .i_wdata ({avs_writedata[31-:DW], avs_writedata[DW-1:0]}),
    .o_rdata (w_op_head),
    .o_count (w_op_cnt),
    .o_full  (w_op_full),
    .o_empty (w_op_empty)
  );

  csq_fifo #(.W(64), .DEPTH(RES_DEPTH)) u_res_fifo (
    .i_clk   (clk_clk),
    .i_rst   (reset_reset),
    .i_clr   (w_fifo_clr),
    .i_push  (w_res_push),
    .i_pop   (w_res_pop),
    .i_wdata (w_res_wdata),
    .o_rdata (w_res_head),
    .o_count (w_res_cnt),
    .o_full  (w_res_full),
    .o_empty (w_res_empty)
  );

  assign w_status = {8'(w_op_cnt), 8'(w_res_cnt), 8'(r_outst),
                     4'd0, r_state, r_udf, r_ovf};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel_re:  w_rdata = w_res_empty ? '0 : w_res_head[63:32];
      w_sel_im:  w_rdata = w_res_empty ? '0 : w_res_head[31:0];
      w_sel_st:  w_rdata = w_status;
      w_sel_ctl: w_rdata = {30'd0, r_ie, r_run};
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state    <= S_IDLE;
      r_run      <= 1'b0;
      r_ie       <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_outst    <= '0;
      r_dp_valid <= 1'b0;
      r_dp_re    <= '0;
      r_dp_im    <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_wr_ctl) begin
        r_run <= avs_writedata[CTRL_RUN_BIT];
        r_ie  <= avs_writedata[CTRL_IE_BIT];
      end
      if (w_flush_req) r_run <= 1'b0;

      if (w_clr_flags) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end
      if (w_op_ovf) r_ovf <= 1'b1;
      if (w_udf)    r_udf <= 1'b1;

      // Returns during flush still retire credit; they are just not stored.
      case ({w_issue, dp_out_valid})
        2'b10:   r_outst <= r_outst + OONE;
        2'b01:   r_outst <= r_outst - OONE;
        default: r_outst <= r_outst;
      endcase

      r_dp_valid <= w_issue;
      if (w_issue) begin
        r_dp_re <= w_op_head[2*DW-1:DW];
        r_dp_im <= w_op_head[DW-1:0];
      end

      r_rdata <= avs_read ? w_rdata : '0;

      if (w_flush_req) begin
        r_state <= S_FLUSH;
      end else begin
        unique case (r_state)
          S_IDLE:  if (r_run) r_state <= S_RUN;
          S_RUN:   if (!r_run) r_state <= S_DRAIN;
          S_DRAIN: begin
            if (r_run)             r_state <= S_RUN;
            else if (r_outst == '0) r_state <= S_IDLE;
          end
          S_FLUSH: if (r_outst == '0) r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign avs_readdata = r_rdata;
  assign dp_in_valid  = r_dp_valid;
  assign dp_in_re     = r_dp_re;
  assign dp_in_im     = r_dp_im;
  assign irq          = r_ie & ~w_res_empty;

endmodule

// File: tb/tb_cmplx_square_ctrl.sv
// tb_cmplx_square_ctrl: scoreboard bench for cmplx_square_ctrl
// with a fixed-latency complex-square datapath model.
`timescale 1ns/1ps
module tb_cmplx_square_ctrl;
  localparam int LAT = 8;
  localparam logic [2:0] A_OP = 3'd0;
  localparam logic [2:0] A_RE = 3'd1;
  localparam logic [2:0] A_IM = 3'd2;
  localparam logic [2:0] A_ST = 3'd3;
  localparam logic [2:0] A_CT = 3'd4;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        dp_in_valid;
  logic [15:0] dp_in_re;
  logic [15:0] dp_in_im;
  logic        dp_out_valid;
  logic [32:0] dp_out_re;
  logic [32:0] dp_out_im;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_op[$];
  logic [63:0] exp_res[$];
  logic [31:0] issued_log[$];
  int issue_cnt = 0;
  int iss_rd = 0;

  always #5 clk = ~clk;

  cmplx_square_ctrl dut (
    .clk_clk       (clk),
    .reset_reset   (reset_reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .dp_in_valid   (dp_in_valid),
    .dp_in_re      (dp_in_re),
    .dp_in_im      (dp_in_im),
    .dp_out_valid  (dp_out_valid),
    .dp_out_re     (dp_out_re),
    .dp_out_im     (dp_out_im)
  );

  function automatic logic signed [32:0] sx(input logic [15:0] a);
    return {{17{a[15]}}, a};
  endfunction

  function automatic logic [32:0] m_re(input logic [31:0] op);
    logic signed [32:0] a, b;
    a = sx(op[31:16]);
    b = sx(op[15:0]);
    return a * a - b * b;
  endfunction

  function automatic logic [32:0] m_im(input logic [31:0] op);
    logic signed [32:0] a, b, p;
    a = sx(op[31:16]);
    b = sx(op[15:0]);
    p = a * b;
    return p <<< 1;
  endfunction

  function automatic logic [31:0] m_red(input logic [32:0] x);
    logic signed [32:0] s;
    s = x;
`ifdef CSQ_SAT_EN
    if (s > 33'sh0_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (s < -33'sh0_8000_0000) return 32'h8000_0000;
`endif
    return x[31:0];
  endfunction

  function automatic logic [63:0] m_res(input logic [31:0] op);
    return {m_red(m_re(op)), m_red(m_im(op))};
  endfunction

  // Datapath model: fixed latency, no backpressure.
  logic        p_v  [LAT];
  logic [32:0] p_re [LAT];
  logic [32:0] p_im [LAT];

  always @(posedge clk) begin
    if (reset_reset) begin
      for (int i = 0; i < LAT; i++) p_v[i] <= 1'b0;
    end else begin
      p_v[0]  <= dp_in_valid;
      p_re[0] <= m_re({dp_in_re, dp_in_im});
      p_im[0] <= m_im({dp_in_re, dp_in_im});
      for (int i = 1; i < LAT; i++) begin
        p_v[i]  <= p_v[i-1];
        p_re[i] <= p_re[i-1];
        p_im[i] <= p_im[i-1];
      end
    end
  end

  assign dp_out_valid = p_v[LAT-1];
  assign dp_out_re    = p_re[LAT-1];
  assign dp_out_im    = p_im[LAT-1];

  always @(negedge clk) begin
    if (dp_in_valid) begin
      issued_log.push_back({dp_in_re, dp_in_im});
      issue_cnt++;
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wr_op(input logic [31:0] op);
    wr(A_OP, op);
    exp_op.push_back(op);
    exp_res.push_back(m_res(op));
  endtask

  task automatic poll(input logic [31:0] mask, input logic [31:0] val,
                      output bit ok, output logic [31:0] st);
    ok = 1'b0;
    st = '0;
    for (int n = 0; n < 100 && !ok; n++) begin
      rd(A_ST, st);
      ok = ((st & mask) == val);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_reset   = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({avs_readdata, dp_in_valid, dp_in_re, dp_in_im, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%h v=%b re=%h im=%h irq=%b required all 0",
               avs_readdata, dp_in_valid, dp_in_re, dp_in_im, irq);
    end
    reset_reset = 1'b0;
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: got %h required 00000000", d);
    end
    rd(A_CT, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h required 00000000", d);
    end
  endtask

  task automatic test_single();
    logic [31:0] d, st;
    logic [63:0] e;
    bit ok;
    int base;
    base = issue_cnt;
    wr(A_CT, 32'h1);
    wr_op(32'h0003_0004);
    poll(32'h00FF_FF00, 32'h0001_0000, ok, st);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_wait: status %h required res count 1, outstanding 0", st);
    end
    checks++;
    if (issue_cnt - base !== 1) begin
      errors++;
      $display("FAIL single_issues: got %0d required 1", issue_cnt - base);
    end
    e = exp_res.pop_front();
    rd(A_RE, d);
    checks++;
    if (d !== e[63:32]) begin
      errors++;
      $display("FAIL single_re: got %h required %h", d, e[63:32]);
    end
    rd(A_IM, d);
    checks++;
    if (d !== e[31:0]) begin
      errors++;
      $display("FAIL single_im: got %h required %h", d, e[31:0]);
    end
    rd(A_ST, d);
    checks++;
    if (d[23:16] !== 8'd0) begin
      errors++;
      $display("FAIL single_rescount: got %0d required 0", d[23:16]);
    end
    while (exp_op.size() > 0) begin
      checks++;
      d = (iss_rd < issued_log.size()) ? issued_log[iss_rd] : 'x;
      if (d !== exp_op[0]) begin
        errors++;
        $display("FAIL single_dp_in: got %h required %h", d, exp_op[0]);
      end
      iss_rd++;
      void'(exp_op.pop_front());
    end
  endtask

  task automatic test_ovf();
    logic [31:0] d, st;
    bit ok;
    wr(A_CT, 32'h0);
    poll(32'h0000_000C, 32'h0, ok, st);
    for (int i = 0; i < 9; i++) wr(A_OP, 32'h0100_0000 + i);
    rd(A_ST, d);
    checks++;
    if ((d & 32'hFF00_0003) !== 32'h0800_0001) begin
      errors++;
      $display("FAIL ovf_set: status %h required op count 8, OVF 1", d);
    end
    wr(A_ST, 32'h1);
    rd(A_ST, d);
    checks++;
    if ((d & 32'hFF00_0003) !== 32'h0800_0000) begin
      errors++;
      $display("FAIL ovf_clear: status %h required op count 8, OVF 0", d);
    end
    wr(A_ST, 32'h2);
    poll(32'hFF00_000F, 32'h0, ok, st);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ovf_flush: status %h required op count 0, IDLE", st);
    end
  endtask

  task automatic test_credit();
    logic [31:0] d, st;
    logic [63:0] e;
    bit ok;
    int base;
    base = issue_cnt;
    wr(A_CT, 32'h1);
    for (int i = 0; i < 12; i++) wr_op($urandom());
    poll(32'hFFFF_FF00, 32'h0408_0000, ok, st);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL credit_fill: status %h required op 4, res 8, outstanding 0", st);
    end
    checks++;
    if (issue_cnt - base !== 8) begin
      errors++;
      $display("FAIL credit_stall: issues %0d required 8", issue_cnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_res.pop_front();
      rd(A_RE, d);
      rd(A_IM, st);
      checks++;
      if ({d, st} !== e) begin
        errors++;
        $display("FAIL credit_res: got %h required %h", {d, st}, e);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (issue_cnt - base !== 9 + i) begin
        errors++;
        $display("FAIL credit_refill: issues %0d required %0d", issue_cnt - base, 9 + i);
      end
    end
    poll(32'hFFFF_FF00, 32'h0008_0000, ok, st);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL credit_tail: status %h required res 8", st);
    end
    while (exp_res.size() > 0) begin
      e = exp_res.pop_front();
      rd(A_RE, d);
      rd(A_IM, st);
      checks++;
      if ({d, st} !== e) begin
        errors++;
        $display("FAIL credit_res: got %h required %h", {d, st}, e);
      end
    end
    while (exp_op.size() > 0) begin
      checks++;
      d = (iss_rd < issued_log.size()) ? issued_log[iss_rd] : 'x;
      if (d !== exp_op[0]) begin
        errors++;
        $display("FAIL credit_dp_in: got %h required %h", d, exp_op[0]);
      end
      iss_rd++;
      void'(exp_op.pop_front());
    end
    wr(A_CT, 32'h0);
    poll(32'h0000_000C, 32'h0, ok, st);
  endtask

  task automatic test_sat();
    logic [31:0] d, st, c;
    logic [63:0] e;
    bit ok;
`ifdef CSQ_SAT_EN
    c = 32'h7FFF_FFFF;
`else
    c = 32'h8000_0000;
`endif
    wr(A_CT, 32'h1);
    wr_op(32'h8000_8000);
    wr_op(32'h7FFF_8000);
    poll(32'h00FF_FF00, 32'h0002_0000, ok, st);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sat_wait: status %h required res 2", st);
    end
    rd(A_RE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL sat_re: got %h required 00000000", d);
    end
    rd(A_IM, d);
    checks++;
    if (d !== c) begin
      errors++;
      $display("FAIL sat_im: got %h required %h", d, c);
    end
    void'(exp_res.pop_front());
    e = exp_res.pop_front();
    rd(A_RE, d);
    rd(A_IM, st);
    checks++;
    if ({d, st} !== e) begin
      errors++;
      $display("FAIL sat_res2: got %h required %h", {d, st}, e);
    end
    while (exp_op.size() > 0) begin
      checks++;
      d = (iss_rd < issued_log.size()) ? issued_log[iss_rd] : 'x;
      if (d !== exp_op[0]) begin
        errors++;
        $display("FAIL sat_dp_in: got %h required %h", d, exp_op[0]);
      end
      iss_rd++;
      void'(exp_op.pop_front());
    end
    wr(A_CT, 32'h0);
    poll(32'h0000_000C, 32'h0, ok, st);
  endtask

  task automatic test_flush();
    logic [31:0] d, st;
    bit ok;
    int base;
    base = issue_cnt;
    wr(A_CT, 32'h1);
    for (int i = 0; i < 2; i++) wr_op($urandom());
    poll(32'h00FF_FF00, 32'h0002_0000, ok, st);
    for (int i = 0; i < 3; i++) wr_op($urandom());
    @(negedge clk);
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0002_0304) begin
      errors++;
      $display("FAIL flush_pre: status %h required 00020304", d);
    end
    wr(A_ST, 32'h2);
    wr(A_OP, 32'h1234_5678);
    rd(A_ST, d);
    checks++;
    if ((d & 32'hFFFF_000F) !== 32'h0000_000C) begin
      errors++;
      $display("FAIL flush_state: status %h required FLUSH, counts 0, flags 0", d);
    end
    poll(32'h0000_000C, 32'h0, ok, st);
    checks++;
    if (!ok || st !== 32'h0) begin
      errors++;
      $display("FAIL flush_idle: status %h required 00000000", st);
    end
    rd(A_CT, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL flush_run: ctrl %h required 00000000", d);
    end
    checks++;
    if (issue_cnt - base !== 5) begin
      errors++;
      $display("FAIL flush_issues: got %0d required 5", issue_cnt - base);
    end
    while (exp_op.size() > 0) begin
      checks++;
      d = (iss_rd < issued_log.size()) ? issued_log[iss_rd] : 'x;
      if (d !== exp_op[0]) begin
        errors++;
        $display("FAIL flush_dp_in: got %h required %h", d, exp_op[0]);
      end
      iss_rd++;
      void'(exp_op.pop_front());
    end
    exp_res.delete();
  endtask

  task automatic test_udf_drain();
    logic [31:0] d, st;
    logic [63:0] e;
    bit ok;
    rd(A_RE, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL udf_re_data: got %h required 00000000", d);
    end
    rd(A_ST, d);
    checks++;
    if (d[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL udf_re_flag: flags %b required 10", d[1:0]);
    end
    wr(A_ST, 32'h1);
    rd(A_IM, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL udf_im_data: got %h required 00000000", d);
    end
    rd(A_ST, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      errors++;
      $display("FAIL udf_im_flag: status %h required 00000002", d);
    end
    wr(A_ST, 32'h1);
    wr(A_CT, 32'h1);
    for (int i = 0; i < 4; i++) wr_op($urandom());
    wr(A_CT, 32'h2);
    @(negedge clk);
    rd(A_ST, d);
    checks++;
    if ((d & 32'h0000_FF0F) !== 32'h0000_0408) begin
      errors++;
      $display("FAIL drain_state: status %h required DRAIN, outstanding 4", d);
    end
    poll(32'h0000_000C, 32'h0, ok, st);
    checks++;
    if (!ok || st !== 32'h0004_0000) begin
      errors++;
      $display("FAIL drain_idle: status %h required 00040000", st);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got %b required 1", irq);
    end
    while (exp_res.size() > 0) begin
      e = exp_res.pop_front();
      rd(A_RE, d);
      rd(A_IM, st);
      checks++;
      if ({d, st} !== e) begin
        errors++;
        $display("FAIL drain_res: got %h required %h", {d, st}, e);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b required 0", irq);
    end
    while (exp_op.size() > 0) begin
      checks++;
      d = (iss_rd < issued_log.size()) ? issued_log[iss_rd] : 'x;
      if (d !== exp_op[0]) begin
        errors++;
        $display("FAIL drain_dp_in: got %h required %h", d, exp_op[0]);
      end
      iss_rd++;
      void'(exp_op.pop_front());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_ovf();
    test_credit();
    test_sat();
    test_flush();
    test_udf_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
